// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes over valid/ready, BPC bytes substituted per cycle through shared inverse S-boxes
module inv_sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);
  localparam int NCHUNK = 16 / BPC;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [127:0] work, nxt;
  logic last;
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] r;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
  assign in_ready = st == IDLE;
  assign last = cnt == CW'(NCHUNK - 1);
  // byte i of the state lives at [127-8i -: 8]; only the chunk selected by cnt is rewritten
  always_comb begin
    nxt = work;
    for (int j = 0; j < BPC; j++)
      nxt[127 - 8 * (int'(cnt) * BPC + j) -: 8] = inv_sbox(work[127 - 8 * (int'(cnt) * BPC + j) -: 8]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      work <= '0;
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          work <= state_in;
          cnt <= '0;
          st <= RUN;
        end
        RUN: begin
          work <= nxt;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state_out <= nxt;
            out_valid <= 1'b1;
            st <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed checks of inv_sub_bytes_seq at BPC=4 (dut 0), BPC=1 (dut 1) and BPC=16 (dut 2)
module tb_inv_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst;
  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic ordy [3];
  logic [127:0] si [3];
  logic [127:0] so [3];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  inv_sub_bytes_seq #(.BPC(4)) dut0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .state_in(si[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(so[0]));
  inv_sub_bytes_seq #(.BPC(1)) dut1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .state_in(si[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(so[1]));
  inv_sub_bytes_seq #(.BPC(16)) dut2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .state_in(si[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(so[2]));
  localparam logic [127:0] V1 = 128'h40bfabf406ee4d3042ca6b997a5c5816;
  localparam logic [127:0] V2 = 128'hf265e8d51fd2397bc3b9976d9076505c;
  localparam logic [127:0] V3 = 128'h41d7c6537d669140dd2f179d02acc51b;
  localparam logic [127:0] S1 = 128'h090862bf6f28e3042c747feeda4a6a47;
  localparam logic [127:0] S2 = 128'h894d9b03c0b512212e56883c6038534a;
  localparam logic [127:0] S3 = 128'h830eb4edff338109c115f05e7791a6af;
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic xfer(input int d, input logic [127:0] din, input logic [127:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    iv[d] = 1'b1;
    si[d] = din;
    ordy[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    si[d] = '0;
    n = 0;
    while (!ov[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'(lat));
    chk(tag, so[d], exp);
    @(negedge clk);
    chk({tag, " back to idle"}, {ov[d], ir[d]}, 2'b01);
  endtask
  initial begin
    int n;
    int lat [3];
    lat[0] = 4;
    lat[1] = 16;
    lat[2] = 1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
      si[i] = '0;
    end
    #2 rst = 1'b1;
    #1;
    chk("reset state", {ov[0], ir[0], so[0]}, {2'b01, 128'h0});
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4, "fips");
    // reset while the block is in RUN, with the previous result still in state_out
    @(negedge clk);
    iv[0] = 1'b1;
    si[0] = V1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("mid-run busy", 128'(ir[0]), 128'(0));
    rst = 1'b1;
    #1;
    chk("mid-run reset", {ov[0], ir[0], so[0]}, {2'b01, 128'h0});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("no output after reset", 128'(ov[0]), 128'(0));
    for (int d = 0; d < 3; d++) begin
      xfer(d, {16{8'h63}}, 128'h0, lat[d], $sformatf("uniform63 dut%0d", d));
      xfer(d, 128'h0, {16{8'h52}}, lat[d], $sformatf("uniform00 dut%0d", d));
      xfer(d, {16{8'h16}}, {16{8'hff}}, lat[d], $sformatf("uniform16 dut%0d", d));
    end
    // backpressure: output held, extra in_valid ignored
    @(negedge clk);
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    si[0] = 128'h0;
    @(negedge clk);
    si[0] = {16{8'h63}};
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall %0d", i), {ov[0], ir[0], so[0]}, {2'b10, {16{8'h52}}});
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("stall release", {ov[0], ir[0], so[0]}, {2'b01, {16{8'h52}}});
    @(negedge clk);
    chk("no second transfer", {ov[0], ir[0]}, 2'b01);
    // back-to-back round trip with in_valid held high
    iv[0] = 1'b1;
    si[0] = S1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov[0] && n < 40);
    chk("rt1 latency", 128'(n), 128'(5));
    chk("rt1", so[0], V1);
    si[0] = S2;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov[0] && n < 40);
    chk("rt2 spacing", 128'(n), 128'(6));
    chk("rt2", so[0], V2);
    si[0] = S3;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov[0] && n < 40);
    chk("rt3 spacing", 128'(n), 128'(6));
    chk("rt3", so[0], V3);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("rt idle", {ov[0], ir[0]}, 2'b01);
    // state_in changes every cycle after the accept edge
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    si[0] = S2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      iv[0] = 1'b0;
      si[0] = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("sampling", {ov[0], so[0]}, {1'b1, V2});
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("sampling done", {ov[0], ir[0]}, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
